// File: rtl/spi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_arbiter
// Purpose  : Shares one single-port synchronous SRAM between the SPI SRAM
//            slave (fixed absolute priority, combinational same-cycle path)
//            and the 6502 CPU bus (req/ready handshake, stalled while the
//            SPI slave holds the RAM, with a saturating starvation monitor).
//
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            en               - clock enable (all state frozen when low)
//            s_addr/s_en/s_wr/s_wdata/s_rdata
//                             - SPI slave access port (cannot stall)
//            c_req/c_wr/c_addr/c_wdata/c_rdata/c_ready/c_starved
//                             - CPU access port with completion pulse
//            ram_addr/ram_en/ram_wr/ram_wdata/ram_rdata
//                             - RAM macro port (1-cycle read latency)
//
// Options  : SPI_MEM_ARBITER_WINDOW_EN - SPI accesses whose address bits
//            above ADDR_W are non-zero are dropped (no RAM access, no CPU
//            blocking) and read back as 8'hFF. Without it those bits are
//            ignored and SPI accesses alias into the RAM.
//
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_W   = 6,
  parameter int MAX_WAIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [23:0]       s_addr,
  input  logic              s_en,
  input  logic              s_wr,
  input  logic [7:0]        s_wdata,
  output logic [7:0]        s_rdata,
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [7:0]        c_wdata,
  output logic [7:0]        c_rdata,
  output logic              c_ready,
  output logic              c_starved,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CPU_RESP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              starved_q, starved_d;
  logic [7:0]        hold_q, hold_d;

  logic              spi_grant;
  logic              cpu_grant;
  logic              cpu_resp;
  logic [23:0]       s_addr_hi;

  // SPI address bits that lie above the RAM address range.
  assign s_addr_hi = s_addr >> ADDR_W;

`ifdef SPI_MEM_ARBITER_WINDOW_EN
  logic oow_q, oow_d;
  logic in_window;

  assign in_window = (s_addr_hi == 24'd0);
  assign spi_grant = s_en && in_window;

  // Remembers that the previous SPI access missed the RAM so its read data
  // can be replaced by the bus-idle pattern.
  always_comb begin
    oow_d = oow_q;
    if (en) begin
      oow_d = s_en && !in_window;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oow_q <= 1'b0;
    end else begin
      oow_q <= oow_d;
    end
  end

  assign s_rdata = oow_q ? 8'hFF : ram_rdata;
`else
  logic unused_s_addr_hi;

  // Upper SPI address bits are deliberately ignored (aliasing).
  assign unused_s_addr_hi = ^s_addr_hi;
  assign spi_grant        = s_en;
  assign s_rdata          = ram_rdata;
`endif

  // The CPU may only use the port when the SPI slave does not claim it.
  assign cpu_grant = !spi_grant && (state_q == ST_IDLE) && c_req && en;
  assign cpu_resp  = (state_q == ST_CPU_RESP) && en;

  // RAM port mux: SPI first, CPU otherwise; CPU values when idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = c_addr;
    ram_wdata = c_wdata;
    if (spi_grant) begin
      ram_en    = 1'b1;
      ram_wr    = s_wr;
      ram_addr  = s_addr[ADDR_W-1:0];
      ram_wdata = s_wdata;
    end else if (cpu_grant) begin
      ram_en    = 1'b1;
      ram_wr    = c_wr;
    end
  end

  // Next-state logic; every register holds its value while en is low.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    starved_d  = starved_q;
    hold_d     = hold_q;
    if (en) begin
      // Starvation flag lags the counter by one cycle.
      starved_d = (wait_cnt_q >= WAIT_W'(MAX_WAIT));
      case (state_q)
        ST_IDLE: begin
          if (cpu_grant) begin
            state_d = ST_CPU_RESP;
          end else if (c_req && spi_grant) begin
            if (wait_cnt_q != {WAIT_W{1'b1}}) begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        ST_CPU_RESP: begin
          state_d    = ST_IDLE;
          hold_d     = ram_rdata;
          wait_cnt_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
      hold_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
      hold_q     <= hold_d;
    end
  end

  assign c_ready   = cpu_resp;
  // The RAM read data is forwarded in the response cycle and held after.
  assign c_rdata   = cpu_resp ? ram_rdata : hold_q;
  assign c_starved = starved_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_arbiter
// Purpose  : Self-checking bench for spi_mem_arbiter. A behavioural RAM
//            macro sits on the RAM port; a transaction-level reference
//            (memory image, outstanding-ack flag, stall tally) predicts
//            every DUT output each cycle. Directed scenarios are followed
//            by a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_arbiter;

  localparam int ADDR_W   = 16;
  localparam int WAIT_W   = 6;
  localparam int MAX_WAIT = 32;
  localparam int SAT      = (1 << WAIT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [23:0]       s_addr;
  logic              s_en;
  logic              s_wr;
  logic [7:0]        s_wdata;
  logic [7:0]        s_rdata;
  logic              c_req;
  logic              c_wr;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_wdata;
  logic [7:0]        c_rdata;
  logic              c_ready;
  logic              c_starved;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic              ram_wr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  spi_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_addr    (s_addr),
    .s_en      (s_en),
    .s_wr      (s_wr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .c_req     (c_req),
    .c_wr      (c_wr),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_ready   (c_ready),
    .c_starved (c_starved),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro: synchronous, 1-cycle read latency, read port holds on writes.
  logic [7:0] ram_mem [0:65535];
  initial begin : g_ram_macro
    ram_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) ram_mem[i] = 8'(i * 37 + 5);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        else        ram_rdata         <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [0:65535];
  bit         m_busy;        // CPU access accepted, ack owed next enabled cycle
  int         m_stalls;      // cycles the waiting CPU lost to the SPI slave
  bit         m_starved;
  logic [7:0] m_port;        // value on the RAM read port
  logic [7:0] m_hold;        // CPU read data remembered after the ack
  bit         m_spi_rd;      // previous SPI access was an in-RAM read
  bit         m_spi_oow;     // previous SPI access missed the RAM window
  bit         ack_seen;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit spi_hits_ram(input logic [23:0] a);
`ifdef SPI_MEM_ARBITER_WINDOW_EN
    return (a >> ADDR_W) == 24'd0;
`else
    return (a == a);
`endif
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit                spi_acc;
    bit                spi_miss;
    bit                cpu_acc;
    bit                ack;
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    #1;
    spi_acc  = s_en && spi_hits_ram(s_addr);
    spi_miss = s_en && !spi_hits_ram(s_addr);
    ack      = m_busy && en;
    cpu_acc  = !spi_acc && !m_busy && c_req && en;
    if (spi_acc) begin
      a = s_addr[ADDR_W-1:0]; w = s_wr; d = s_wdata;
    end else begin
      a = c_addr; w = c_wr; d = c_wdata;
    end
    check_eq("ram_en", 32'(ram_en), 32'(spi_acc || cpu_acc));
    if (spi_acc || cpu_acc) begin
      check_eq("ram_addr", 32'(ram_addr), 32'(a));
      check_eq("ram_wr", 32'(ram_wr), 32'(w));
      if (w) check_eq("ram_wdata", 32'(ram_wdata), 32'(d));
    end else begin
      check_eq("ram_wr_idle", 32'(ram_wr), 32'd0);
    end
    check_eq("c_ready", 32'(c_ready), 32'(ack));
    check_eq("c_rdata", 32'(c_rdata), 32'(ack ? m_port : m_hold));
    check_eq("c_starved", 32'(c_starved), 32'(m_starved));
    if (m_spi_oow)     check_eq("s_rdata_oow", 32'(s_rdata), 32'hFF);
    else if (m_spi_rd) check_eq("s_rdata", 32'(s_rdata), 32'(m_port));
    @(posedge clk);
    if (en) begin
      m_starved = (m_stalls >= MAX_WAIT);
      if (ack) begin
        m_hold   = m_port;
        m_stalls = 0;
      end else if (c_req && spi_acc && !m_busy && m_stalls < SAT) begin
        m_stalls++;
      end
      m_busy    = cpu_acc;
      m_spi_oow = spi_miss;
      m_spi_rd  = spi_acc && !s_wr;
    end
    if (spi_acc || cpu_acc) begin
      if (w) ref_mem[a] = d;
      else   m_port     = ref_mem[a];
    end
    if (ack) ack_seen = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_stalls  = 0;
    m_starved = 1'b0;
    m_hold    = 8'h00;
    m_spi_rd  = 1'b0;
    m_spi_oow = 1'b0;
  endtask

  // Asserts reset right away (asynchronously) and releases it a cycle later.
  task automatic apply_reset();
    rst = 1'b1; s_en = 1'b0; c_req = 1'b0;
    model_reset();
    #1;
    check_eq("rst_c_ready", 32'(c_ready), 32'd0);
    check_eq("rst_c_starved", 32'(c_starved), 32'd0);
    check_eq("rst_c_rdata", 32'(c_rdata), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cpu_start(input logic [ADDR_W-1:0] a, input bit w, input logic [7:0] d);
    c_req = 1'b1; c_addr = a; c_wr = w; c_wdata = d; ack_seen = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 200 && !ack_seen; i++) cycle();
    check_eq("cpu_ack_timeout", 32'(ack_seen), 32'd1);
    c_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; s_en = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    c_req = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0; ack_seen = 1'b0;
    m_port = 8'h00;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 5);
    @(negedge clk);
    apply_reset();

    // 1: uncontended write then read of 0x1234; data held after c_req drops.
    cpu_start(16'h1234, 1'b1, 8'h5A); wait_ack(); cycle();
    cpu_start(16'h1234, 1'b0, 8'h00); wait_ack();
    cycle(); cycle();
    check_eq("t1_hold", 32'(c_rdata), 32'h5A);

    // 2: CPU write stalled by three SPI reads of 0x0010.
    cpu_start(16'h0200, 1'b1, 8'h77);
    s_en = 1'b1; s_wr = 1'b0; s_addr = 24'h000010;
    repeat (3) cycle();
    check_eq("t2_stalled", 32'(ack_seen), 32'd0);
    s_en = 1'b0;
    cycle(); cycle();
    check_eq("t2_ack", 32'(ack_seen), 32'd1);
    check_eq("t2_s_rdata", 32'(s_rdata), 32'(ref_mem[16]));
    c_req = 1'b0;
    cycle();

    // 3: SPI write during the CPU response cycle.
    cpu_start(16'h0200, 1'b0, 8'h00);
    cycle();
    s_en = 1'b1; s_wr = 1'b1; s_addr = 24'h000300; s_wdata = 8'h11;
    cycle();
    check_eq("t3_ack", 32'(ack_seen), 32'd1);
    s_en = 1'b0; c_req = 1'b0;
    cycle();
    check_eq("t3_c_rdata", 32'(c_rdata), 32'h77);
    cpu_start(16'h0300, 1'b0, 8'h00); wait_ack(); cycle();
    check_eq("t3_spi_wr", 32'(c_rdata), 32'h11);

    // 4: starvation monitor.
    cpu_start(16'h1234, 1'b0, 8'h00);
    s_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s_en = 1'b1; s_addr = 24'($urandom_range(0, 63));
      cycle();
    end
    check_eq("t4_starved", 32'(c_starved), 32'd1);
    s_en = 1'b0;
    wait_ack();
    cycle(); cycle();
    check_eq("t4_starved_clr", 32'(c_starved), 32'd0);

    // 5: en low mid-request, then reset during CPU_RESP of a write.
    cpu_start(16'h0040, 1'b1, 8'h5C);
    en = 1'b0;
    repeat (5) cycle();
    check_eq("t5_frozen", 32'(ack_seen), 32'd0);
    en = 1'b1;
    cycle();
    apply_reset();
    cycle();
    cpu_start(16'h0040, 1'b0, 8'h00); wait_ack(); cycle();
    check_eq("t5_committed", 32'(c_rdata), 32'h5C);

`ifdef SPI_MEM_ARBITER_WINDOW_EN
    // 6: out-of-window SPI read does not block the CPU and reads as 0xFF.
    cpu_start(16'h0010, 1'b0, 8'h00);
    s_en = 1'b1; s_wr = 1'b0; s_addr = 24'h010005;
    cycle();
    s_en = 1'b0;
    cycle();
    check_eq("t6_ack", 32'(ack_seen), 32'd1);
    c_req = 1'b0;
    cycle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      en = ($urandom % 10) != 0;
      if (c_req && ack_seen) c_req = 1'b0;
      if (!c_req && ($urandom % 3) == 0)
        cpu_start(16'($urandom_range(0, 63)), 1'($urandom), 8'($urandom));
      s_en    = en && (($urandom % 3) == 0);
      s_wr    = 1'($urandom);
      s_wdata = 8'($urandom);
      s_addr  = {(($urandom % 4) == 0) ? 8'($urandom) : 8'h00, 16'($urandom_range(0, 63))};
      cycle();
    end
    s_en = 1'b0; en = 1'b1;
    if (c_req && !ack_seen) wait_ack();
    c_req = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the SPI SRAM slave (host debug/load path) and the 6502 CPU bus.
- The SPI slave cannot stall, so it has fixed absolute priority and a combinational same-cycle path to the RAM.
- The CPU uses a req/ready handshake. It is stalled while the SPI slave holds the RAM, with a saturating starvation monitor.
- Sits between spi_sram_slave, the CPU memory interface and the RAM macro.

Parameters:
- ADDR_W, 16, RAM address width. SPI address bits above ADDR_W are ignored unless the optional feature is enabled.
- WAIT_W, 6, width of the CPU stall counter.
- MAX_WAIT, 32, stall count at or above which c_starved asserts. Must be < 2**WAIT_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  clock enable; shared with the SPI slave.
- s_addr  in  24  SPI slave address.
- s_en  in  1  SPI access request. Already gated with en; single-cycle.
- s_wr  in  1  SPI write qualifier.
- s_wdata  in  8  SPI write data.
- s_rdata  out  8  SPI read data, valid the cycle after s_en.
- c_req  in  1  CPU request; held high with c_addr/c_wr/c_wdata stable until c_ready.
- c_wr  in  1  CPU write qualifier.
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  8  CPU write data.
- c_rdata  out  8  CPU read data, valid when c_ready = 1 and held afterwards.
- c_ready  out  1  one-cycle completion pulse.
- c_starved  out  1  stall counter >= MAX_WAIT.
- ram_addr  out  ADDR_W  RAM address.
- ram_en  out  1  RAM access strobe.
- ram_wr  out  1  RAM write strobe.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, 1-cycle latency.

Behaviour:
- Reset:
  - state = IDLE; stall counter = 0; c_rdata hold register = 0.
  - c_ready = 0; c_starved = 0; ram_en = 0.
- States:
  - IDLE: CPU access may be issued.
  - CPU_RESP: CPU data/ack cycle.
- Grant (combinational, evaluated in any state):
  - SPI grant when s_en = 1. ram_addr = s_addr[ADDR_W-1:0], ram_wr = s_wr, ram_wdata = s_wdata, ram_en = 1.
  - Otherwise CPU grant when state = IDLE, c_req = 1 and en = 1. ram_addr = c_addr, ram_wr = c_wr, ram_wdata = c_wdata, ram_en = 1.
  - Otherwise ram_en = 0, ram_wr = 0, ram_addr/ram_wdata = CPU values (don't-care).
- Transitions (only when en = 1; with en = 0 all registers freeze and c_ready = 0):
  - IDLE -> CPU_RESP on CPU grant.
  - IDLE -> IDLE when c_req = 1 and s_en = 1. This is a stall: stall counter += 1, saturating at 2**WAIT_W-1.
  - CPU_RESP -> IDLE unconditionally.
- CPU_RESP outputs:
  - c_ready = 1.
  - c_rdata = ram_rdata combinationally; the hold register loads ram_rdata.
  - Stall counter cleared.
  - For writes, c_rdata is don't-care and the hold register still loads.
- Outside CPU_RESP: c_rdata = hold register.
- CPU latency: uncontended access is issued in cycle N, c_ready in N+1. Back-to-back throughput is 1 access per 2 cycles. Each SPI cycle coinciding with an IDLE request adds 1 cycle.
- SPI access during CPU_RESP is legal. The RAM port is free that cycle; ram_rdata belongs to the CPU access, and the SPI data appears next cycle.
- s_rdata = ram_rdata passthrough.
- c_req dropped before c_ready: illegal. If c_req is low in IDLE, no access is issued.
- Reset mid-CPU_RESP: c_ready is not produced; the CPU must re-request. A write issued before the reset is committed.
- c_starved is registered from the stall counter and clears the cycle after the counter clears.

Optional Feature:
- Macro: SPI_MEM_ARBITER_WINDOW_EN.
- With the macro: an SPI access with s_addr[23:ADDR_W] != 0 is out of window.
  - No ram_en, and it does not block a CPU grant that cycle.
  - A registered flag forces s_rdata = 8'hFF in the following cycle.
- Without the macro: upper SPI address bits are ignored, so SPI accesses alias into RAM.

Test Plan:
- CPU read 0x1234, RAM holds 0x5A, no SPI traffic -> ram_en in cycle N, c_ready = 1 and c_rdata = 0x5A in N+1; c_rdata still 0x5A after c_req drops.
- CPU write 0x0200 = 0x77 while s_en = 1 for 3 cycles (SPI read 0x0010) -> 3 stall cycles with no CPU ram_en. CPU write issued in cycle 4, c_ready in cycle 5. SPI receives RAM[0x0010] on s_rdata.
- CPU request completes; in CPU_RESP s_en = 1 writes 0x0300 = 0x11 -> c_rdata correct for the CPU address; RAM[0x0300] = 0x11.
- s_en held every cycle for 40 cycles with c_req = 1 -> c_starved rises after 32 stalls, and clears one cycle after the eventual CPU grant completes.
- en = 0 for 5 cycles mid-request, then rst pulsed during CPU_RESP -> state frozen while en = 0; after reset c_ready = 0, c_starved = 0, c_rdata = 0.
- With SPI_MEM_ARBITER_WINDOW_EN, SPI read at 0x010005 while CPU requests -> no SPI RAM access, CPU granted the same cycle, s_rdata = 0xFF next cycle.
